fetch_mem_responder: RTL
========================

# fetch_mem_responder

Memory-side responder for the instruction fetch port. It accepts a one-cycle fetch request (`req_valid`/`req_addr`) from the instruction cache and reads consecutive bytes from the shared byte-wide RAM port, respecting that port's grant. It assembles a 32-bit little-endian instruction word and returns it with a one-cycle `rsp_valid` pulse. It is RVC-aware: when the first byte shows a compressed instruction (`[1:0] != 2'b11`), only 2 bytes are fetched.

## Interface
- ADDR_WIDTH, 17, RAM byte-address width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  abort the current fetch; synchronous
- req_valid  in  1  fetch request pulse
- req_addr  in  32  byte address of the instruction; halfword-aligned
- busy  out  1  fetch in progress; requests are dropped while high
- mem_rd  out  1  byte read request to the shared RAM port
- mem_a  out  ADDR_WIDTH  RAM byte address
- mem_gnt  in  1  arbiter grant; a byte is issued when mem_rd && mem_gnt
- mem_din  in  8  RAM read data, valid the cycle after issue
- rsp_valid  out  1  one-cycle pulse: rsp_data and rsp_addr are valid
- rsp_data  out  32  assembled instruction; upper 16 bits are zero for compressed
- rsp_addr  out  32  req_addr of the fetch being answered

## Operation
- States: IDLE, FETCH.
- IDLE + req_valid: latch req_addr; drive mem_a <= req_addr[ADDR_WIDTH-1:0] and mem_rd <= 1; clear issue and receive counters; set need = 4; go to FETCH.
- FETCH, issue side:
  - On each cycle with mem_rd && mem_gnt, byte issue_cnt is issued and issue_cnt increments.
  - mem_a advances to base + issue_cnt, truncated to ADDR_WIDTH (wraps at 2^ADDR_WIDTH − 1 → 0).
  - mem_rd deasserts once issue_cnt reaches need.
  - With mem_gnt low, mem_a and mem_rd hold.
- FETCH, receive side:
  - The cycle after each issue, mem_din is written to byte lane recv_cnt of the word; recv_cnt increments.
  - When lane 0 arrives with mem_din[1:0] != 2'b11, need becomes 2 and any pending issue of byte 2 is suppressed that same cycle.
- Completion: when recv_cnt reaches need, the next cycle drives rsp_valid = 1 with the word and rsp_addr, and the block returns to IDLE.
- busy = (state == FETCH) || rsp_valid cycle.
- req_valid while busy: ignored, no state change.
- flush, or rst, in any state: go to IDLE, mem_rd = 0, and the in-flight byte is discarded.
  - No rsp_valid is produced for the aborted fetch.
  - flush wins over a same-cycle req_valid.
  - flush in the rsp_valid cycle does not retract the pulse already on the outputs.
- Reset values: busy 0, mem_rd 0, mem_a 0, rsp_valid 0, rsp_data 0, rsp_addr 0, state IDLE.

## Timing
- All outputs are registered.
- With mem_gnt held high and the request sampled in cycle 0:
  - Full 32-bit instruction: bytes issued in cycles 1–4, last data in cycle 5, rsp_valid in cycle 6.
  - Compressed instruction: bytes issued in cycles 1–2, byte 0 decoded in cycle 2, no issue in cycle 3, rsp_valid in cycle 4.
- Each cycle with mem_gnt low before the last issue adds exactly one cycle of latency.
- A new req_valid is accepted in the cycle after rsp_valid at the earliest (back-to-back throughput is 1 per latency + 1).

## Structure
- Shared package holds:
  - the state enum (IDLE, FETCH);
  - the RVC length constant `INSN_LEN_FULL = 2'b11`;
  - the byte counts `NEED_FULL = 3'd4` and `NEED_RVC = 3'd2`.
- Single module. The byte-lane assembly is simple enough to stay inline; no sub-module.

## Test plan
- RAM bytes 0x00–0x03 = 13 05 10 00, req_addr = 0, gnt always 1 -> rsp_valid in cycle 6, rsp_data = 0x00100513, rsp_addr = 0, exactly 4 issues.
- Bytes at 0x10 = 05 45 (c.li), req_addr = 0x10 -> rsp_valid in cycle 4, rsp_data = 0x00004505, exactly 2 issues, mem_a never 0x12.
- Full fetch with mem_gnt low in cycles 2 and 3 -> mem_a holds during the stall, rsp_valid in cycle 8, data identical to the no-stall case.
- flush in cycle 3 of a full fetch -> mem_rd = 0 next cycle, no rsp_valid ever; a new req in cycle 5 -> correct response for the new address.
- req_valid pulsed while busy, then req_valid together with flush in IDLE -> both dropped, busy stays 0 after the flush.
- req_addr = 2^ADDR_WIDTH − 2, uncompressed -> byte addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001, rsp_addr = 0x1FFFE.

Source files
------------

// File: rtl/fetch_mem_responder_pkg.sv
// Shared definitions for the instruction-fetch memory responder.
//   state_e        : responder FSM states
//   INSN_LEN_FULL  : low two bits of a 32-bit (non-compressed) RISC-V instruction
//   NEED_FULL/RVC  : number of bytes to fetch for full / compressed instructions
package fetch_mem_responder_pkg;

    typedef enum logic {
        IDLE,
        FETCH
    } state_e;

    localparam logic [1:0] INSN_LEN_FULL = 2'b11;
    localparam logic [2:0] NEED_FULL     = 3'd4;
    localparam logic [2:0] NEED_RVC      = 3'd2;

endpackage

// File: rtl/fetch_mem_responder.sv
// Memory-side responder for the instruction fetch port.
// Reads up to four consecutive bytes over a granted byte-wide RAM port and returns a
// little-endian 32-bit instruction word. Stops after two bytes for compressed (RVC)
// instructions.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              abort the current fetch
//   req_valid/req_addr fetch request pulse and byte address
//   busy               fetch in progress (requests dropped while high)
//   mem_rd/mem_a       byte read request and address to the shared RAM port
//   mem_gnt            arbiter grant; a byte issues when mem_rd && mem_gnt
//   mem_din            RAM read data, valid the cycle after issue
//   rsp_valid          one-cycle pulse qualifying rsp_data/rsp_addr
//   rsp_data/rsp_addr  assembled instruction and its request address
module fetch_mem_responder
    import fetch_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    input  logic [31:0]           req_addr,
    output logic                  busy,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_a,
    input  logic                  mem_gnt,
    input  logic [7:0]            mem_din,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_data,
    output logic [31:0]           rsp_addr
);

    state_e                state_q, state_d;
    logic [31:0]           base_q, base_d;
    logic [2:0]            issue_cnt_q, issue_cnt_d;
    logic [2:0]            recv_cnt_q, recv_cnt_d;
    logic [2:0]            need_q, need_d;
    logic                  pend_q, pend_d;      // a byte was issued last cycle
    logic [31:0]           word_q, word_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic [31:0]           rsp_addr_q, rsp_addr_d;
    logic                  busy_q, busy_d;

    logic                  issue;
    logic [31:0]           word_ins;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        need_d      = need_q;
        pend_d      = 1'b0;
        word_d      = word_q;
        mem_rd_d    = mem_rd_q;
        mem_a_d     = mem_a_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;

        issue    = mem_rd_q && mem_gnt;
        // Current word with the incoming byte merged into its lane.
        word_ins = word_q;
        word_ins[{recv_cnt_q[1:0], 3'b000} +: 8] = mem_din;

        if (flush) begin
            // Abort: the byte in flight (if any) is dropped because pend_d stays 0.
            state_d  = IDLE;
            mem_rd_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // The rsp_valid cycle is still busy even though the FSM is idle.
                    if (req_valid && !rsp_valid_q) begin
                        base_d      = req_addr;
                        mem_a_d     = req_addr[ADDR_WIDTH-1:0];
                        mem_rd_d    = 1'b1;
                        issue_cnt_d = 3'd0;
                        recv_cnt_d  = 3'd0;
                        need_d      = NEED_FULL;
                        word_d      = '0;
                        state_d     = FETCH;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        issue_cnt_d = issue_cnt_q + 3'd1;
                    end
                    pend_d = issue;
                    if (pend_q) begin
                        word_d     = word_ins;
                        recv_cnt_d = recv_cnt_q + 3'd1;
                        if (recv_cnt_q == 3'd0 && mem_din[1:0] != INSN_LEN_FULL) begin
                            need_d = NEED_RVC;
                        end
                    end
                    // Uses need_d so a compressed decode cancels the next issue at once.
                    mem_rd_d = (issue_cnt_d < need_d);
                    // Only move the address when another byte will actually be read.
                    if (issue && mem_rd_d) begin
                        mem_a_d = base_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(issue_cnt_d);
                    end
                    if (pend_q && recv_cnt_d == need_d) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = word_ins;
                        rsp_addr_d  = base_q;
                        mem_rd_d    = 1'b0;
                        pend_d      = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == FETCH) || rsp_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            need_q      <= NEED_FULL;
            pend_q      <= 1'b0;
            word_q      <= '0;
            mem_rd_q    <= 1'b0;
            mem_a_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            need_q      <= need_d;
            pend_q      <= pend_d;
            word_q      <= word_d;
            mem_rd_q    <= mem_rd_d;
            mem_a_q     <= mem_a_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign mem_rd    = mem_rd_q;
    assign mem_a     = mem_a_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;

endmodule
